// File: rtl/s_spi_msg_responder.sv
// SPI mode-0 slave: oversampled in I_CLK, stores received bytes in a 64-entry display buffer.
// Optional SPI_SLV_ECHO_EN: MISO echoes the previously received byte instead of "SLAVE".
module s_spi_msg_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int MSG_DEPTH   = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         I_CLK,
  input  logic                         I_RESETN,
  input  logic                         SCLK_SLAVE,
  input  logic                         SS_N_SLAVE,
  input  logic                         MOSI_SLAVE,
  output logic                         MISO_SLAVE,
  input  logic [$clog2(MSG_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [DATA_WIDTH-1:0]        rx_byte,
  output logic                         rx_valid,
  output logic [$clog2(MSG_DEPTH)-1:0] wr_index,
  output logic                         busy
);

  localparam int IDX_W = $clog2(MSG_DEPTH);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic                   miso_q, miso_d;
  logic [DATA_WIDTH-1:0]  rx_byte_q, rx_byte_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [IDX_W-1:0]       wr_index_q, wr_index_d;
  logic [DATA_WIDTH-1:0]  rx_buf_q [MSG_DEPTH];
  logic [DATA_WIDTH-1:0]  rx_buf_d [MSG_DEPTH];
  logic [DATA_WIDTH-1:0]  rx_next;
  logic [DATA_WIDTH-1:0]  load_byte;

`ifndef SPI_SLV_ECHO_EN
  logic [IDX_W-1:0]       tx_index_q, tx_index_d;

  function automatic logic [DATA_WIDTH-1:0] tx_rom(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): tx_rom = DATA_WIDTH'(8'h53);
      IDX_W'(1): tx_rom = DATA_WIDTH'(8'h4C);
      IDX_W'(2): tx_rom = DATA_WIDTH'(8'h41);
      IDX_W'(3): tx_rom = DATA_WIDTH'(8'h56);
      IDX_W'(4): tx_rom = DATA_WIDTH'(8'h45);
      default:   tx_rom = '0;
    endcase
  endfunction

  assign load_byte = tx_rom(tx_index_q);
`else
  assign load_byte = rx_byte_q;
`endif

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK_SLAVE};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_N_SLAVE};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI_SLAVE};
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    wr_index_d = wr_index_q;
    rx_buf_d   = rx_buf_q;
    rx_next    = '0;
`ifndef SPI_SLV_ECHO_EN
    tx_index_d = tx_index_q;
`endif
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          tx_shift_d = load_byte;
          miso_d     = load_byte[DATA_WIDTH-1];
          bit_cnt_d  = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_next    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d  = '0;
            rx_byte_d  = rx_next;
            rx_valid_d = 1'b1;
            // Writing slot 0 starts a fresh displayed message.
            if (wr_index_q == '0) begin
              for (int unsigned i = 1; i < MSG_DEPTH; i++) rx_buf_d[IDX_W'(i)] = '0;
            end
            rx_buf_d[wr_index_q] = rx_next;
            wr_index_d = wr_index_q + 1'b1;
`ifdef SPI_SLV_ECHO_EN
            tx_shift_d = rx_next;
`else
            tx_index_d = tx_index_q + 1'b1;
            tx_shift_d = tx_rom(tx_index_d);
`endif
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end else begin
            miso_d = tx_shift_q[DATA_WIDTH-1];
          end
        end
        // A same-cycle byte completion above is kept; only a partial byte is dropped.
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      wr_index_q  <= '0;
`ifndef SPI_SLV_ECHO_EN
      tx_index_q  <= '0;
`endif
      for (int unsigned i = 0; i < MSG_DEPTH; i++) rx_buf_q[IDX_W'(i)] <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      wr_index_q  <= wr_index_d;
`ifndef SPI_SLV_ECHO_EN
      tx_index_q  <= tx_index_d;
`endif
      for (int unsigned i = 0; i < MSG_DEPTH; i++) rx_buf_q[IDX_W'(i)] <= rx_buf_d[IDX_W'(i)];
    end
  end

  assign MISO_SLAVE = miso_q;
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign wr_index   = wr_index_q;
  assign busy       = (state_q == ACTIVE);
  assign rd_data    = rx_buf_q[rd_addr];

endmodule

// File: tb/tb_s_spi_msg_responder.sv
// Bench for s_spi_msg_responder: SPI master model at I_CLK/10 with scoreboarded MISO and rx bytes.
module tb_s_spi_msg_responder;

  logic       I_CLK = 1'b0;
  logic       I_RESETN = 1'b0;
  logic       SCLK_SLAVE = 1'b0;
  logic       SS_N_SLAVE = 1'b1;
  logic       MOSI_SLAVE = 1'b0;
  logic       MISO_SLAVE;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [5:0] wr_index;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_buf [64];
  int         m_idx;
  logic [7:0] m_last;
  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] obs_rx_q[$];

  s_spi_msg_responder #(.DATA_WIDTH(8), .MSG_DEPTH(64), .SYNC_STAGES(2)) dut (
    .I_CLK(I_CLK), .I_RESETN(I_RESETN), .SCLK_SLAVE(SCLK_SLAVE), .SS_N_SLAVE(SS_N_SLAVE),
    .MOSI_SLAVE(MOSI_SLAVE), .MISO_SLAVE(MISO_SLAVE), .rd_addr(rd_addr), .rd_data(rd_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .wr_index(wr_index), .busy(busy)
  );

  always #5 I_CLK = ~I_CLK;

  always @(negedge I_CLK) if (rx_valid === 1'b1) obs_rx_q.push_back(rx_byte);

  function automatic logic [7:0] rom_char(input int idx);
    case (idx)
      0: return 8'h53;
      1: return 8'h4C;
      2: return 8'h41;
      3: return 8'h56;
      4: return 8'h45;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_idx = 0;
    m_last = 8'h00;
    for (int i = 0; i < 64; i++) m_buf[i] = 8'h00;
    exp_miso_q.delete();
    exp_rx_q.delete();
    obs_rx_q.delete();
  endtask

  // Predicts the MISO byte for a full frame, then commits the frame to the model.
  task automatic model_byte(input logic [7:0] b);
`ifdef SPI_SLV_ECHO_EN
    exp_miso_q.push_back(m_last);
`else
    exp_miso_q.push_back(rom_char(m_idx));
`endif
    if (m_idx == 0) for (int i = 1; i < 64; i++) m_buf[i] = 8'h00;
    m_buf[m_idx] = b;
    m_idx = (m_idx + 1) % 64;
    m_last = b;
    exp_rx_q.push_back(b);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge I_CLK);
  endtask

  task automatic do_reset();
    @(negedge I_CLK);
    I_RESETN = 1'b0;
    SCLK_SLAVE = 1'b0;
    SS_N_SLAVE = 1'b1;
    MOSI_SLAVE = 1'b0;
    clks(4);
    I_RESETN = 1'b1;
    clks(4);
    model_reset();
  endtask

  task automatic ss_begin();
    SS_N_SLAVE = 1'b0;
    clks(6);
  endtask

  task automatic ss_end();
    clks(6);
    SS_N_SLAVE = 1'b1;
    clks(8);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI_SLAVE = b[7-i];
      clks(5);
      got = {got[6:0], MISO_SLAVE};
      SCLK_SLAVE = 1'b1;
      clks(5);
      SCLK_SLAVE = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (MISO_SLAVE !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", MISO_SLAVE); end
    n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_checks++; if (wr_index !== 6'd0) begin n_fail++; $display("FAIL reset_wr_index got=%0d exp=0", wr_index); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rd_addr = 6'd0; #1;
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
  endtask

  task automatic test_message();
    logic [7:0] msg [6];
    logic [7:0] got, e, o;
    msg = '{8'h4D, 8'h41, 8'h53, 8'h54, 8'h45, 8'h52};
    do_reset();
    ss_begin();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL msg_busy got=%b exp=1", busy); end
    for (int i = 0; i < 6; i++) begin
      model_byte(msg[i]);
      send_bits(msg[i], 8, got);
      e = exp_miso_q.pop_front();
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL msg_miso[%0d] got=%h exp=%h", i, got, e); end
    end
    ss_end();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL msg_busy_end got=%b exp=0", busy); end
    n_checks++; if (wr_index !== 6'(m_idx)) begin n_fail++; $display("FAIL msg_wr_index got=%0d exp=%0d", wr_index, m_idx); end
    for (int i = 0; i < 6; i++) begin
      rd_addr = 6'(i); #1;
      n_checks++; if (rd_data !== m_buf[i]) begin n_fail++; $display("FAIL msg_rd[%0d] got=%h exp=%h", i, rd_data, m_buf[i]); end
    end
    n_checks++; if (obs_rx_q.size() != exp_rx_q.size()) begin n_fail++; $display("FAIL msg_pulses got=%0d exp=%0d", obs_rx_q.size(), exp_rx_q.size()); end
    while (obs_rx_q.size() > 0 && exp_rx_q.size() > 0) begin
      o = obs_rx_q.pop_front(); e = exp_rx_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL msg_rx got=%h exp=%h", o, e); end
    end
    clks(1);
  endtask

  task automatic test_partial();
    logic [7:0] got, e, o;
    do_reset();
    ss_begin();
    send_bits(8'hA5, 3, got);
    ss_end();
    n_checks++; if (obs_rx_q.size() != 0) begin n_fail++; $display("FAIL partial_no_pulse got=%0d exp=0", obs_rx_q.size()); end
    ss_begin();
    model_byte(8'h3C);
    send_bits(8'h3C, 8, got);
    e = exp_miso_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL partial_miso got=%h exp=%h", got, e); end
    ss_end();
    n_checks++; if (rx_byte !== m_last) begin n_fail++; $display("FAIL partial_rx_byte got=%h exp=%h", rx_byte, m_last); end
    n_checks++; if (wr_index !== 6'(m_idx)) begin n_fail++; $display("FAIL partial_wr_index got=%0d exp=%0d", wr_index, m_idx); end
    n_checks++; if (obs_rx_q.size() != exp_rx_q.size()) begin n_fail++; $display("FAIL partial_pulses got=%0d exp=%0d", obs_rx_q.size(), exp_rx_q.size()); end
    while (obs_rx_q.size() > 0 && exp_rx_q.size() > 0) begin
      o = obs_rx_q.pop_front(); e = exp_rx_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL partial_rx got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got, e, o, b;
    int bad;
    do_reset();
    ss_begin();
    bad = 0;
    for (int i = 0; i < 65; i++) begin
      b = (i < 64) ? 8'(i) : 8'h41;
      model_byte(b);
      send_bits(b, 8, got);
      e = exp_miso_q.pop_front();
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL wrap_miso[%0d] got=%h exp=%h", i, got, e); end
    end
    ss_end();
    n_checks++; if (wr_index !== 6'(m_idx)) begin n_fail++; $display("FAIL wrap_wr_index got=%0d exp=%0d", wr_index, m_idx); end
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i); #1;
      n_checks++; if (rd_data !== m_buf[i]) begin n_fail++; $display("FAIL wrap_rd[%0d] got=%h exp=%h", i, rd_data, m_buf[i]); end
    end
    n_checks++; if (obs_rx_q.size() != exp_rx_q.size()) begin n_fail++; $display("FAIL wrap_pulses got=%0d exp=%0d", obs_rx_q.size(), exp_rx_q.size()); end
    while (obs_rx_q.size() > 0 && exp_rx_q.size() > 0) begin
      o = obs_rx_q.pop_front(); e = exp_rx_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL wrap_rx got=%h exp=%h", o, e); end
    end
    clks(1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, e, o;
    do_reset();
    ss_begin();
    model_byte(8'h12);
    send_bits(8'h12, 8, got);
    e = exp_miso_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rstmid_miso0 got=%h exp=%h", got, e); end
    send_bits(8'h34, 4, got);
    MOSI_SLAVE = 1'b0;
    SCLK_SLAVE = 1'b1;
    clks(2);
    I_RESETN = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (wr_index !== 6'd0) begin n_fail++; $display("FAIL rstmid_wr_index got=%0d exp=0", wr_index); end
    n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_byte got=%h exp=00", rx_byte); end
    n_checks++; if (MISO_SLAVE !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso got=%b exp=0", MISO_SLAVE); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid got=%b exp=0", rx_valid); end
    SCLK_SLAVE = 1'b0;
    SS_N_SLAVE = 1'b1;
    clks(3);
    I_RESETN = 1'b1;
    clks(4);
    model_reset();
    ss_begin();
    model_byte(8'h55);
    send_bits(8'h55, 8, got);
    e = exp_miso_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rstmid_miso_after got=%h exp=%h", got, e); end
    ss_end();
    n_checks++; if (wr_index !== 6'(m_idx)) begin n_fail++; $display("FAIL rstmid_wr_after got=%0d exp=%0d", wr_index, m_idx); end
    n_checks++; if (obs_rx_q.size() != exp_rx_q.size()) begin n_fail++; $display("FAIL rstmid_pulses got=%0d exp=%0d", obs_rx_q.size(), exp_rx_q.size()); end
    while (obs_rx_q.size() > 0 && exp_rx_q.size() > 0) begin
      o = obs_rx_q.pop_front(); e = exp_rx_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_rx got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, e, o;
    bit seen;
    do_reset();
    ss_begin();
    model_byte(8'h7E);
    send_bits(8'h7E, 7, got);
    MOSI_SLAVE = 1'b0;
    clks(5);
    got = {got[6:0], MISO_SLAVE};
    SCLK_SLAVE = 1'b1;
    SS_N_SLAVE = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge I_CLK);
      if (rx_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL simul_pulse_timeout got=0 exp=1"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy got=%b exp=0", busy); end
    n_checks++; if (rx_byte !== 8'h7E) begin n_fail++; $display("FAIL simul_rx_byte got=%h exp=7e", rx_byte); end
    clks(3);
    SCLK_SLAVE = 1'b0;
    clks(8);
    e = exp_miso_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL simul_miso got=%h exp=%h", got, e); end
    n_checks++; if (wr_index !== 6'(m_idx)) begin n_fail++; $display("FAIL simul_wr_index got=%0d exp=%0d", wr_index, m_idx); end
    n_checks++; if (obs_rx_q.size() != exp_rx_q.size()) begin n_fail++; $display("FAIL simul_pulses got=%0d exp=%0d", obs_rx_q.size(), exp_rx_q.size()); end
    while (obs_rx_q.size() > 0 && exp_rx_q.size() > 0) begin
      o = obs_rx_q.pop_front(); e = exp_rx_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL simul_rx got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_stream();
    logic [7:0] seq [3];
    logic [7:0] got, e, o;
    seq = '{8'h11, 8'h22, 8'h33};
    do_reset();
    ss_begin();
    for (int i = 0; i < 3; i++) begin
      model_byte(seq[i]);
      send_bits(seq[i], 8, got);
      e = exp_miso_q.pop_front();
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL stream_miso[%0d] got=%h exp=%h", i, got, e); end
    end
    ss_end();
    n_checks++; if (obs_rx_q.size() != exp_rx_q.size()) begin n_fail++; $display("FAIL stream_pulses got=%0d exp=%0d", obs_rx_q.size(), exp_rx_q.size()); end
    while (obs_rx_q.size() > 0 && exp_rx_q.size() > 0) begin
      o = obs_rx_q.pop_front(); e = exp_rx_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL stream_rx got=%h exp=%h", o, e); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_message();
    test_partial();
    test_wrap();
    test_reset_mid();
    test_simultaneous();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
